rs_station: RTL and testbench

Parametrised reservation station for the Tomasulo core. It holds up to DEPTH dispatched instructions per functional-unit class. Each entry waits for its two source operands, either delivered at dispatch or captured by snooping the common data bus (CDB). The oldest fully-ready entry is issued to the execution unit over a valid/ready handshake. One instance sits between the dispatch stage and each execution unit (add/branch/ld-st class, mul/div class); the ROB index is carried through as the result tag.

---
 rtl/rs_station.sv | 178 +++++++++++++++++
 tb/tb_rs_station.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station.sv
// Reservation station: holds dispatched instructions until both operands are
// present (at dispatch or via CDB snoop), then issues the oldest ready entry.
// Optional macro RS_CDB_BYPASS_EN lets a CDB broadcast make an entry issuable
// in the same cycle it arrives.
module rs_station #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 16,
    parameter  int TAGW  = 3,
    parameter  int FW    = 4,
    parameter  int RW    = 4,
    localparam int OCW   = $clog2(DEPTH + 1)
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic            flush,
    input  logic            disp_valid,
    output logic            disp_ready,
    input  logic [FW-1:0]   disp_func,
    input  logic [RW-1:0]   disp_rd,
    input  logic [TAGW-1:0] disp_rob,
    input  logic            disp_s1_rdy,
    input  logic            disp_s2_rdy,
    input  logic [DW-1:0]   disp_s1_val,
    input  logic [DW-1:0]   disp_s2_val,
    input  logic [TAGW-1:0] disp_s1_tag,
    input  logic [TAGW-1:0] disp_s2_tag,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [DW-1:0]   cdb_data,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [FW-1:0]   iss_func,
    output logic [RW-1:0]   iss_rd,
    output logic [TAGW-1:0] iss_rob,
    output logic [DW-1:0]   iss_s1,
    output logic [DW-1:0]   iss_s2,
    output logic [OCW-1:0]  occupancy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OCW-1:0] DEPTH_C = OCW'(DEPTH);

    logic [DEPTH-1:0] valid_r;
    logic [FW-1:0]    func_r   [DEPTH];
    logic [RW-1:0]    rd_r     [DEPTH];
    logic [TAGW-1:0]  rob_r    [DEPTH];
    logic [DEPTH-1:0] s1_rdy_r;
    logic [DEPTH-1:0] s2_rdy_r;
    logic [DW-1:0]    s1_val_r [DEPTH];
    logic [DW-1:0]    s2_val_r [DEPTH];
    logic [TAGW-1:0]  s1_tag_r [DEPTH];
    logic [TAGW-1:0]  s2_tag_r [DEPTH];
    // older_r[j][i] set means entry j was allocated before entry i
    logic [DEPTH-1:0] older_r  [DEPTH];
    logic [OCW-1:0]   occ_r;

    logic [DEPTH-1:0] s1_hit_s, s2_hit_s, s1_ok_s, s2_ok_s;
    logic [DEPTH-1:0] elig_s, blk_s, pick_s;
    logic [DW-1:0]    s1_eff_s [DEPTH];
    logic [DW-1:0]    s2_eff_s [DEPTH];
    logic [IW-1:0]    iss_idx_s, free_idx_s;
    logic             iss_any_s, clr_s, disp_fire_s, iss_fire_s;
    logic             disp_s1_cap_s, disp_s2_cap_s;

    // CDB tag match per pending source and the operand view used for issue
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s1_hit_s[i] = valid_r[i] & ~s1_rdy_r[i] & cdb_valid & (s1_tag_r[i] == cdb_tag);
            s2_hit_s[i] = valid_r[i] & ~s2_rdy_r[i] & cdb_valid & (s2_tag_r[i] == cdb_tag);
`ifdef RS_CDB_BYPASS_EN
            s1_ok_s[i]  = s1_rdy_r[i] | s1_hit_s[i];
            s2_ok_s[i]  = s2_rdy_r[i] | s2_hit_s[i];
            s1_eff_s[i] = s1_rdy_r[i] ? s1_val_r[i] : cdb_data;
            s2_eff_s[i] = s2_rdy_r[i] ? s2_val_r[i] : cdb_data;
`else
            s1_ok_s[i]  = s1_rdy_r[i];
            s2_ok_s[i]  = s2_rdy_r[i];
            s1_eff_s[i] = s1_val_r[i];
            s2_eff_s[i] = s2_val_r[i];
`endif
        end
        elig_s = valid_r & s1_ok_s & s2_ok_s;
    end

    // Oldest-eligible selection: an entry is blocked by any older eligible entry
    always_comb begin
        blk_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blk_s[i] = blk_s[i] | (elig_s[j] & older_r[j][i]);
            end
        end
        pick_s    = elig_s & ~blk_s;
        iss_idx_s = '0;
        iss_any_s = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            iss_idx_s = pick_s[i] ? IW'(i) : iss_idx_s;
            iss_any_s = iss_any_s | pick_s[i];
        end
    end

    // Lowest-index free slot for allocation
    always_comb begin
        free_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = ~valid_r[i] ? IW'(i) : free_idx_s;
        end
    end

    // Handshakes and issue outputs; fields are zeroed whenever nothing is offered
    always_comb begin
        clr_s         = rst | flush;
        disp_ready    = ~clr_s & (occ_r < DEPTH_C);
        iss_valid     = iss_any_s & ~clr_s;
        disp_fire_s   = disp_valid & disp_ready;
        iss_fire_s    = iss_valid & iss_ready;
        disp_s1_cap_s = ~disp_s1_rdy & cdb_valid & (disp_s1_tag == cdb_tag);
        disp_s2_cap_s = ~disp_s2_rdy & cdb_valid & (disp_s2_tag == cdb_tag);
        occupancy     = occ_r;
        if (iss_valid) begin
            iss_func = func_r[iss_idx_s];
            iss_rd   = rd_r[iss_idx_s];
            iss_rob  = rob_r[iss_idx_s];
            iss_s1   = s1_eff_s[iss_idx_s];
            iss_s2   = s2_eff_s[iss_idx_s];
        end else begin
            iss_func = '0;
            iss_rd   = '0;
            iss_rob  = '0;
            iss_s1   = '0;
            iss_s2   = '0;
        end
    end

    // Entry state: clear, wakeup, issue-free and allocation
    always_ff @(posedge clk1) begin
        if (clr_s) begin
            valid_r <= '0;
            occ_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (s1_hit_s[i]) begin
                    s1_rdy_r[i] <= 1'b1;
                    s1_val_r[i] <= cdb_data;
                end
                if (s2_hit_s[i]) begin
                    s2_rdy_r[i] <= 1'b1;
                    s2_val_r[i] <= cdb_data;
                end
            end
            if (iss_fire_s) begin
                valid_r[iss_idx_s] <= 1'b0;
            end
            if (disp_fire_s) begin
                valid_r[free_idx_s]  <= 1'b1;
                func_r[free_idx_s]   <= disp_func;
                rd_r[free_idx_s]     <= disp_rd;
                rob_r[free_idx_s]    <= disp_rob;
                s1_tag_r[free_idx_s] <= disp_s1_tag;
                s2_tag_r[free_idx_s] <= disp_s2_tag;
                s1_rdy_r[free_idx_s] <= disp_s1_rdy | disp_s1_cap_s;
                s2_rdy_r[free_idx_s] <= disp_s2_rdy | disp_s2_cap_s;
                s1_val_r[free_idx_s] <= disp_s1_rdy ? disp_s1_val : cdb_data;
                s2_val_r[free_idx_s] <= disp_s2_rdy ? disp_s2_val : cdb_data;
                older_r[free_idx_s]  <= '0;
                // Every currently valid entry is older than the new one
                for (int j = 0; j < DEPTH; j++) begin
                    older_r[j][free_idx_s] <= valid_r[j];
                end
            end
            occ_r <= occ_r + OCW'(disp_fire_s) - OCW'(iss_fire_s);
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios plus random traffic, checked by a
// queue-based reference model and a decoupled scoreboard monitor.
module tb_rs_station;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int TAGW  = 3;
    localparam int FW    = 4;
    localparam int RW    = 4;
    localparam int OCW   = $clog2(DEPTH + 1);

    logic            clk1, rst, flush;
    logic            disp_valid, disp_ready;
    logic [FW-1:0]   disp_func;
    logic [RW-1:0]   disp_rd;
    logic [TAGW-1:0] disp_rob;
    logic            disp_s1_rdy, disp_s2_rdy;
    logic [DW-1:0]   disp_s1_val, disp_s2_val;
    logic [TAGW-1:0] disp_s1_tag, disp_s2_tag;
    logic            cdb_valid;
    logic [TAGW-1:0] cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic            iss_valid, iss_ready;
    logic [FW-1:0]   iss_func;
    logic [RW-1:0]   iss_rd;
    logic [TAGW-1:0] iss_rob;
    logic [DW-1:0]   iss_s1, iss_s2;
    logic [OCW-1:0]  occupancy;

    rs_station #(.DEPTH(DEPTH), .DW(DW), .TAGW(TAGW), .FW(FW), .RW(RW)) dut (
        .clk1(clk1), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_func(disp_func), .disp_rd(disp_rd), .disp_rob(disp_rob),
        .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
        .disp_s1_val(disp_s1_val), .disp_s2_val(disp_s2_val),
        .disp_s1_tag(disp_s1_tag), .disp_s2_tag(disp_s2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
        .iss_s1(iss_s1), .iss_s2(iss_s2), .occupancy(occupancy)
    );

    typedef struct {
        logic [FW-1:0]   func;
        logic [RW-1:0]   rd;
        logic [TAGW-1:0] rob;
        logic            r1, r2;
        logic [DW-1:0]   v1, v2;
        logic [TAGW-1:0] t1, t2;
    } ent_t;

    typedef struct packed {
        logic [FW-1:0]   func;
        logic [RW-1:0]   rd;
        logic [TAGW-1:0] rob;
        logic [DW-1:0]   s1;
        logic [DW-1:0]   s2;
    } iss_t;

    ent_t mq[$];      // model entries, oldest first
    iss_t exp_q[$];   // expected issues, in order
    logic [OCW-1:0] exp_occ;
    logic exp_dr, exp_iv;
    int checks = 0;
    int failures = 0;

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Reference model: evaluated mid-cycle with stable inputs, commits the coming edge
    always @(negedge clk1) begin
        int sel;
        ent_t e;
        iss_t x;
        logic ok1, ok2;
        exp_occ = OCW'(mq.size());
        exp_dr  = !rst && !flush && (mq.size() < DEPTH);
        sel = -1;
        for (int k = 0; k < mq.size(); k++) begin
`ifdef RS_CDB_BYPASS_EN
            ok1 = mq[k].r1 || (cdb_valid && cdb_tag == mq[k].t1);
            ok2 = mq[k].r2 || (cdb_valid && cdb_tag == mq[k].t2);
`else
            ok1 = mq[k].r1;
            ok2 = mq[k].r2;
`endif
            if (sel < 0 && ok1 && ok2) sel = k;
        end
        exp_iv = !rst && !flush && (sel >= 0);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (exp_iv && iss_ready) begin
                e = mq[sel];
                x.func = e.func; x.rd = e.rd; x.rob = e.rob;
                x.s1 = e.r1 ? e.v1 : cdb_data;
                x.s2 = e.r2 ? e.v2 : cdb_data;
                exp_q.push_back(x);
                mq.delete(sel);
            end
            if (cdb_valid) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (!mq[k].r1 && mq[k].t1 == cdb_tag) begin mq[k].r1 = 1'b1; mq[k].v1 = cdb_data; end
                    if (!mq[k].r2 && mq[k].t2 == cdb_tag) begin mq[k].r2 = 1'b1; mq[k].v2 = cdb_data; end
                end
            end
            if (disp_valid && exp_dr) begin
                e.func = disp_func; e.rd = disp_rd; e.rob = disp_rob;
                e.t1 = disp_s1_tag; e.t2 = disp_s2_tag;
                e.r1 = disp_s1_rdy || (cdb_valid && cdb_tag == disp_s1_tag);
                e.r2 = disp_s2_rdy || (cdb_valid && cdb_tag == disp_s2_tag);
                e.v1 = disp_s1_rdy ? disp_s1_val : cdb_data;
                e.v2 = disp_s2_rdy ? disp_s2_val : cdb_data;
                mq.push_back(e);
            end
        end
    end

    // Scoreboard monitor: samples the DUT just after the model has run
    always @(negedge clk1) begin
        iss_t got, want;
        #1;
        checks++;
        if (occupancy !== exp_occ) begin
            failures++;
            $display("FAIL occupancy got=%0d exp=%0d t=%0t", occupancy, exp_occ, $time);
        end
        checks++;
        if (disp_ready !== exp_dr) begin
            failures++;
            $display("FAIL disp_ready got=%0b exp=%0b t=%0t", disp_ready, exp_dr, $time);
        end
        checks++;
        if (iss_valid !== exp_iv) begin
            failures++;
            $display("FAIL iss_valid got=%0b exp=%0b t=%0t", iss_valid, exp_iv, $time);
        end
        got = {iss_func, iss_rd, iss_rob, iss_s1, iss_s2};
        if (iss_valid === 1'b1 && iss_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected got rob=%0d none expected t=%0t", iss_rob, $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL issue_fields got f=%h rd=%h rob=%0d s1=%h s2=%h exp f=%h rd=%h rob=%0d s1=%h s2=%h t=%0t",
                             iss_func, iss_rd, iss_rob, iss_s1, iss_s2,
                             want.func, want.rd, want.rob, want.s1, want.s2, $time);
                end
            end
        end else if (iss_valid === 1'b0) begin
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL idle_fields got=%h exp=0 t=%0t", got, $time);
            end
        end
    end

    task automatic cyc();
        @(posedge clk1);
        #2;
    endtask

    task automatic disp(input logic [FW-1:0] f, input logic [RW-1:0] rd, input logic [TAGW-1:0] rob,
                        input logic r1, input logic [DW-1:0] v1, input logic [TAGW-1:0] t1,
                        input logic r2, input logic [DW-1:0] v2, input logic [TAGW-1:0] t2);
        disp_valid = 1'b1; disp_func = f; disp_rd = rd; disp_rob = rob;
        disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
        disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
    endtask

    task automatic idle(input int n);
        disp_valid = 1'b0; cdb_valid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        disp_func = '0; disp_rd = '0; disp_rob = '0;
        disp_s1_rdy = 1'b0; disp_s2_rdy = 1'b0; disp_s1_val = '0; disp_s2_val = '0;
        disp_s1_tag = '0; disp_s2_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        repeat (2) cyc();
        rst = 1'b0;
        idle(1);

        // Ready dispatch, then accept
        iss_ready = 1'b1;
        disp(4'h0, 4'h1, 3'd2, 1'b1, 16'd5, 3'd0, 1'b1, 16'd7, 3'd0);
        cyc();
        idle(2);

        // Wakeup of a pending source from the CDB
        iss_ready = 1'b0;
        disp(4'h3, 4'h2, 3'd1, 1'b0, 16'd0, 3'd3, 1'b1, 16'd9, 3'd0);
        cyc();
        idle(1);
        iss_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h0011;
        cyc();
        idle(2);

        // Fill to full with ready entries, stall, then drain in age order
        iss_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            disp(4'(k), 4'(k + 8), 3'(k), 1'b1, 16'(k * 3), 3'd0, 1'b1, 16'(k + 100), 3'd0);
            cyc();
        end
        disp(4'hF, 4'hF, 3'd7, 1'b1, 16'hDEAD, 3'd0, 1'b1, 16'hBEEF, 3'd0);
        cyc();
        iss_ready = 1'b1;
        idle(DEPTH + 1);

        // Same-cycle capture at dispatch
        disp(4'h5, 4'h6, 3'd4, 1'b1, 16'h0101, 3'd0, 1'b0, 16'd0, 3'd5);
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h00AA;
        cyc();
        idle(2);

        // Flush with waiting entries and a concurrent dispatch
        iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(4'h7, 4'(k), 3'(k), 1'b0, 16'd0, 3'd7, 1'b1, 16'(k), 3'd0);
            cyc();
        end
        flush = 1'b1;
        disp(4'h9, 4'h9, 3'd6, 1'b1, 16'd1, 3'd0, 1'b1, 16'd2, 3'd0);
        cyc();
        flush = 1'b0;
        iss_ready = 1'b1;
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 16'h7777;
        cyc();
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 79) == 0);
            disp(4'($urandom), 4'($urandom), 3'($urandom),
                 ($urandom_range(0, 2) == 0), 16'($urandom), 3'($urandom),
                 ($urandom_range(0, 2) == 0), 16'($urandom), 3'($urandom));
            disp_valid = ($urandom_range(0, 9) < 6);
            cdb_valid  = ($urandom_range(0, 9) < 5);
            cdb_tag    = 3'($urandom);
            cdb_data   = 16'($urandom);
            iss_ready  = ($urandom_range(0, 9) < 5);
            cyc();
        end
        rst = 1'b0; flush = 1'b0;
        idle(2);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL issue_missing got=0 exp=%0d pending", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
